// File: rtl/pipe_perf_pkg.sv
// Shared definitions for the pipeline performance counter block: counter
// select codes, FSM state encoding and default counter width.
package pipe_perf_pkg;

    localparam int CNT_W_DEF = 32;
    localparam int NUM_CNT   = 4;

    localparam logic [1:0] SEL_CYCLE  = 2'd0;
    localparam logic [1:0] SEL_RETIRE = 2'd1;
    localparam logic [1:0] SEL_STALL  = 2'd2;
    localparam logic [1:0] SEL_FLUSH  = 2'd3;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        FROZEN = 2'd2
    } perf_state_e;

endpackage

// File: rtl/pipe_perf_counter_if.sv
// Event strobes and read port of pipe_perf_counter.
// snap_i exists only when PIPE_PERF_SNAPSHOT_EN is defined.
interface pipe_perf_counter_if #(
    parameter int CNT_W = 32
);
    logic             start_i;
    logic             freeze_i;
    logic             clr_i;
    logic             stall_i;
    logic             branch_i;
    logic             flush_i;
    logic             retire_i;
    logic             rd_req_i;
    logic [1:0]       rd_sel_i;
`ifdef PIPE_PERF_SNAPSHOT_EN
    logic             snap_i;
`endif
    logic             rd_valid_o;
    logic [CNT_W-1:0] rd_data_o;
    logic             running_o;

    modport slave (
`ifdef PIPE_PERF_SNAPSHOT_EN
        input  snap_i,
`endif
        input  start_i, freeze_i, clr_i, stall_i, branch_i, flush_i, retire_i,
        input  rd_req_i, rd_sel_i,
        output rd_valid_o, rd_data_o, running_o
    );

    modport master (
`ifdef PIPE_PERF_SNAPSHOT_EN
        output snap_i,
`endif
        output start_i, freeze_i, clr_i, stall_i, branch_i, flush_i, retire_i,
        output rd_req_i, rd_sel_i,
        input  rd_valid_o, rd_data_o, running_o
    );

endinterface

// File: rtl/sat_counter.sv
// Single saturating up-counter; clear overrides any increment and acts
// regardless of the enable.
module sat_counter #(
    parameter int CNT_W = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             en_i,
    input  logic             inc_i,
    input  logic             clr_i,
    output logic [CNT_W-1:0] cnt_o
);

    localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && inc_i && (cnt_q != '1)) begin
            cnt_d = cnt_q + ONE;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/pipe_perf_counter.sv
// Performance counter unit: cycle/retire/load-use-stall/flush counters with
// a registered read port. PIPE_PERF_SNAPSHOT_EN adds coherent shadow copies.
module pipe_perf_counter
    import pipe_perf_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic                clk_i,
    input  logic                rst_i,
    pipe_perf_counter_if.slave  bus
);

    perf_state_e      state_q;
    perf_state_e      state_d;
    logic             count_en;
    logic [NUM_CNT-1:0] cnt_inc;
    logic [CNT_W-1:0] cnt_val [NUM_CNT];
    logic [CNT_W-1:0] rd_src  [NUM_CNT];
    logic             rd_valid_q;
    logic             rd_valid_d;
    logic [CNT_W-1:0] rd_data_q;
    logic [CNT_W-1:0] rd_data_d;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (bus.start_i && !bus.freeze_i) state_d = RUN;
            RUN:     if (bus.freeze_i)     state_d = FROZEN;
                     else if (!bus.start_i) state_d = IDLE;
            FROZEN:  if (!bus.freeze_i)    state_d = bus.start_i ? RUN : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Freeze suspends counting in the very cycle it is raised.
    assign count_en = (state_q == RUN) && !bus.freeze_i;

    always_comb begin
        cnt_inc             = '0;
        cnt_inc[SEL_CYCLE]  = 1'b1;
        cnt_inc[SEL_RETIRE] = bus.retire_i;
        cnt_inc[SEL_STALL]  = bus.stall_i & ~bus.branch_i;
        cnt_inc[SEL_FLUSH]  = bus.flush_i;
    end

    generate
        for (genvar gi = 0; gi < NUM_CNT; gi++) begin : g_cnt
            sat_counter #(.CNT_W(CNT_W)) u_cnt (
                .clk_i (clk_i),
                .rst_i (rst_i),
                .en_i  (count_en),
                .inc_i (cnt_inc[gi]),
                .clr_i (bus.clr_i),
                .cnt_o (cnt_val[gi])
            );
`ifdef PIPE_PERF_SNAPSHOT_EN
            // Shadow samples the live value before any same-edge clear.
            logic [CNT_W-1:0] shadow_q;
            logic [CNT_W-1:0] shadow_d;

            always_comb begin
                shadow_d = shadow_q;
                if (bus.snap_i) shadow_d = cnt_val[gi];
            end

            always_ff @(posedge clk_i or negedge rst_i) begin
                if (!rst_i) begin
                    shadow_q <= '0;
                end else begin
                    shadow_q <= shadow_d;
                end
            end

            assign rd_src[gi] = shadow_q;
`else
            assign rd_src[gi] = cnt_val[gi];
`endif
        end
    endgenerate

    always_comb begin
        rd_valid_d = bus.rd_req_i;
        rd_data_d  = rd_data_q;
        if (bus.rd_req_i) rd_data_d = rd_src[bus.rd_sel_i];
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            rd_valid_q <= rd_valid_d;
            rd_data_q  <= rd_data_d;
        end
    end

    assign bus.rd_valid_o = rd_valid_q;
    assign bus.rd_data_o  = rd_data_q;
    assign bus.running_o  = (state_q == RUN);

endmodule

// File: tb/tb_pipe_perf_counter.sv
// Directed bench for pipe_perf_counter: vector table for the main flow plus
// hand sequences for saturation, snapshot and asynchronous reset.
module tb_pipe_perf_counter;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    pipe_perf_counter_if #(.CNT_W(32)) bus ();
    pipe_perf_counter_if #(.CNT_W(4))  s_bus ();

    pipe_perf_counter #(.CNT_W(32)) dut (
        .clk_i (clk),
        .rst_i (rst_n),
        .bus   (bus)
    );

    pipe_perf_counter #(.CNT_W(4)) dut_small (
        .clk_i (clk),
        .rst_i (rst_n),
        .bus   (s_bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        start;
        logic        freeze;
        logic        clr;
        logic        stall;
        logic        branch;
        logic        flush;
        logic        retire;
        logic        rd_req;
        logic [1:0]  sel;
        logic        exp_valid;
        logic [31:0] exp_data;
        logic        exp_running;
    } vec_t;

    vec_t vecs[$];

    function automatic void addv(input logic st, input logic fz, input logic cl,
                                 input logic stl, input logic br, input logic fl,
                                 input logic rt, input logic rq, input logic [1:0] sel,
                                 input logic ev, input logic [31:0] ed, input logic er);
        vec_t v;
        v.start = st; v.freeze = fz; v.clr = cl; v.stall = stl; v.branch = br;
        v.flush = fl; v.retire = rt; v.rd_req = rq; v.sel = sel;
        v.exp_valid = ev; v.exp_data = ed; v.exp_running = er;
        vecs.push_back(v);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.start_i = 0; bus.freeze_i = 0; bus.clr_i = 0; bus.stall_i = 0;
        bus.branch_i = 0; bus.flush_i = 0; bus.retire_i = 0; bus.rd_req_i = 0;
        bus.rd_sel_i = 2'd0;
        s_bus.start_i = 0; s_bus.freeze_i = 0; s_bus.clr_i = 0; s_bus.stall_i = 0;
        s_bus.branch_i = 0; s_bus.flush_i = 0; s_bus.retire_i = 0; s_bus.rd_req_i = 0;
        s_bus.rd_sel_i = 2'd0;
`ifdef PIPE_PERF_SNAPSHOT_EN
        bus.snap_i = 0;
        s_bus.snap_i = 0;
`endif
    endtask

    task automatic read_main(input string name, input logic [1:0] sel, input logic [31:0] exp);
        bus.rd_req_i = 1; bus.rd_sel_i = sel;
        step();
        bus.rd_req_i = 0;
        chk({name, "_valid"}, 32'(bus.rd_valid_o), 32'd1);
        chk(name, bus.rd_data_o, exp);
    endtask

    task automatic read_small(input string name, input logic [1:0] sel, input logic [31:0] exp);
        s_bus.rd_req_i = 1; s_bus.rd_sel_i = sel;
        step();
        s_bus.rd_req_i = 0;
        chk({name, "_valid"}, 32'(s_bus.rd_valid_o), 32'd1);
        chk(name, 32'(s_bus.rd_data_o), exp);
    endtask

    initial begin
        checks = 0;
        failures = 0;
        rst_n = 1'b0;
        idle_inputs();

        // Cycle counter starts one edge after start_i is first sampled.
        for (int i = 0; i < 11; i++) addv(1,0,0,0,0,0,0,0,2'd0, 0,32'd0,1);
        addv(1,0,0,0,0,0,0,1,2'd0, 1,32'd10,1);
        addv(1,0,0,0,0,0,0,1,2'd1, 1,32'd0,1);
        addv(1,0,0,0,0,0,0,1,2'd2, 1,32'd0,1);
        addv(1,0,0,0,0,0,0,1,2'd3, 1,32'd0,1);
        addv(1,0,0,0,0,0,0,0,2'd0, 0,32'd0,1);
        for (int i = 0; i < 3; i++) addv(1,0,0,1,0,0,0,0,2'd0, 0,32'd0,1);
        for (int i = 0; i < 2; i++) addv(1,0,0,1,1,0,0,0,2'd0, 0,32'd0,1);
        addv(1,0,0,0,0,0,0,1,2'd2, 1,32'd3,1);
        for (int i = 0; i < 5; i++) addv(1,0,0,0,0,1,0,0,2'd0, 0,32'd3,1);
        addv(1,1,0,0,0,1,0,0,2'd0, 0,32'd3,0);
        addv(1,1,0,0,0,1,0,0,2'd0, 0,32'd3,0);
        addv(1,1,0,0,0,1,0,1,2'd0, 1,32'd26,0);
        addv(1,1,0,0,0,1,0,1,2'd3, 1,32'd5,0);
        addv(1,0,0,0,0,0,0,1,2'd0, 1,32'd26,1);
        addv(1,0,0,0,0,0,0,1,2'd3, 1,32'd5,1);
        addv(1,0,1,0,0,0,0,0,2'd0, 0,32'd5,1);
        for (int i = 0; i < 20; i++) addv(1,0,0,0,0,0,0,0,2'd0, 0,32'd5,1);
        addv(1,0,1,0,0,0,0,1,2'd0, 1,32'd20,1);
        addv(1,0,0,0,0,0,0,1,2'd0, 1,32'd0,1);
        addv(1,0,0,0,0,0,0,1,2'd1, 1,32'd0,1);
        addv(1,0,0,0,0,0,0,1,2'd2, 1,32'd0,1);
        addv(1,0,0,0,0,0,0,1,2'd3, 1,32'd0,1);
        for (int i = 0; i < 3; i++) addv(1,0,0,0,0,0,1,0,2'd0, 0,32'd0,1);
        addv(1,0,0,0,0,0,0,1,2'd1, 1,32'd3,1);
        addv(0,0,0,0,0,0,0,0,2'd0, 0,32'd3,0);
        addv(0,0,0,0,0,0,0,1,2'd0, 1,32'd9,0);
        addv(0,0,0,0,0,0,0,1,2'd0, 1,32'd9,0);
        addv(0,0,0,1,0,0,0,0,2'd0, 0,32'd9,0);
        addv(0,0,0,0,0,0,0,1,2'd2, 1,32'd0,0);

        repeat (3) @(posedge clk);
        #1;
        chk("reset_valid",   32'(bus.rd_valid_o), 32'd0);
        chk("reset_data",    bus.rd_data_o,       32'd0);
        chk("reset_running", 32'(bus.running_o),  32'd0);
        rst_n = 1'b1;
        step();

`ifndef PIPE_PERF_SNAPSHOT_EN
        for (int i = 0; i < vecs.size(); i++) begin
            bus.start_i  = vecs[i].start;  bus.freeze_i = vecs[i].freeze;
            bus.clr_i    = vecs[i].clr;    bus.stall_i  = vecs[i].stall;
            bus.branch_i = vecs[i].branch; bus.flush_i  = vecs[i].flush;
            bus.retire_i = vecs[i].retire; bus.rd_req_i = vecs[i].rd_req;
            bus.rd_sel_i = vecs[i].sel;
            step();
            chk($sformatf("v%0d_valid", i),   32'(bus.rd_valid_o), 32'(vecs[i].exp_valid));
            chk($sformatf("v%0d_data", i),    bus.rd_data_o,       vecs[i].exp_data);
            chk($sformatf("v%0d_running", i), 32'(bus.running_o),  32'(vecs[i].exp_running));
            $display("vec %0d sel=%0d valid=%0b data=%0d running=%0b",
                     i, vecs[i].sel, bus.rd_valid_o, bus.rd_data_o, bus.running_o);
        end
        idle_inputs();
        step();
`endif

        // Saturation on a 4-bit instance: 19 increments must stop at 15.
        s_bus.start_i = 1; s_bus.retire_i = 1;
        repeat (20) step();
        s_bus.start_i = 0; s_bus.retire_i = 0;
        step();
`ifdef PIPE_PERF_SNAPSHOT_EN
        s_bus.snap_i = 1;
        step();
        s_bus.snap_i = 0;
`endif
        read_small("sat_cycle",  2'd0, 32'd15);
        read_small("sat_retire", 2'd1, 32'd15);
        read_small("sat_stall",  2'd2, 32'd0);
        $display("saturation reads done");

`ifdef PIPE_PERF_SNAPSHOT_EN
        bus.start_i = 1; bus.clr_i = 1;
        step();
        bus.clr_i = 0;
        repeat (30) step();
        chk("snap_running", 32'(bus.running_o), 32'd1);
        bus.snap_i = 1; step(); bus.snap_i = 0;
        repeat (8) step();
        read_main("snap_first", 2'd0, 32'd30);
        bus.snap_i = 1; step(); bus.snap_i = 0;
        read_main("snap_second", 2'd0, 32'd40);
        bus.snap_i = 1; bus.clr_i = 1; step(); bus.snap_i = 0; bus.clr_i = 0;
        read_main("snap_pre_clear", 2'd0, 32'd42);
        $display("snapshot reads done");
`endif

        // Asynchronous reset while a read is outstanding.
        bus.start_i = 1;
        bus.rd_req_i = 1; bus.rd_sel_i = 2'd0;
        repeat (3) step();
        chk("prereset_valid", 32'(bus.rd_valid_o), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("async_rst_valid",   32'(bus.rd_valid_o), 32'd0);
        chk("async_rst_data",    bus.rd_data_o,       32'd0);
        chk("async_rst_running", 32'(bus.running_o),  32'd0);
        $display("async reset mid-read checked");
        idle_inputs();
        step();
        rst_n = 1'b1;
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
